inst_rom_arbiter: RTL and testbench
===================================

Name: inst_rom_arbiter

Overview:
- Shares the single combinational instruction ROM read port between two requesters: requester 0 (IF-stage fetch) and requester 1 (testbench loader/debug port).
- Round-robin arbitration; one ROM access per cycle; registered response one cycle after acceptance.
- Per-requester response is held until consumed, with one outstanding access per requester.
- Flags misaligned addresses instead of reading the ROM.

Parameters:
ADDR_W, 32, width of request and ROM addresses (matches InstAddrBus)
DATA_W, 32, instruction width (matches InstBus)

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active high
req0_valid  input  1  requester 0 fetch request
req0_addr  input  ADDR_W  requester 0 byte address
req0_ready  output  1  requester 0 request accepted this cycle
rsp0_valid  output  1  requester 0 response available
rsp0_inst  output  DATA_W  requester 0 instruction word
rsp0_err  output  1  requester 0 misaligned-address response
rsp0_ready  input  1  requester 0 consumes response
req1_valid, req1_addr, req1_ready, rsp1_valid, rsp1_inst, rsp1_err, rsp1_ready: same as requester 0, for requester 1
rom_ce  output  1  ROM chip enable (1 = enable, 0 = disable)
rom_addr  output  ADDR_W  ROM byte address
rom_inst  input  DATA_W  ROM read data (combinational from rom_ce/rom_addr)

Behaviour:
- Reset (rst=1 at posedge): rspN_valid=0, rspN_inst=0, rspN_err=0, last_grant=1, so requester 0 wins the first contention. Pending responses are discarded. rst overrides everything in the same cycle.
- Eligibility: eligN = !rspN_valid || rspN_ready. A consumed response frees its slot in the same cycle.
- Grant (combinational, at most one per cycle):
  - candN = reqN_valid && eligN.
  - If only one candidate, grant it.
  - If both are candidates, grant the requester != last_grant.
  - reqN_ready = grantN. No grant while rst=1.
- Acceptance: reqN_valid && reqN_ready. last_grant updates to N on acceptance and is unchanged otherwise.
- ROM drive:
  - rom_addr = granted address, else 0.
  - rom_ce = 1 only if a grant exists and the granted addr[1:0]==0; else 0.
- Response register, at the posedge of acceptance:
  - rspN_valid <= 1.
  - Aligned address: rspN_inst <= rom_inst, rspN_err <= 0.
  - Misaligned address: rspN_inst <= 0, rspN_err <= 1.
- Latency: response visible exactly 1 cycle after acceptance.
- Hold: while rspN_valid && !rspN_ready, rspN_inst and rspN_err stay stable and reqN_ready=0.
- Clear: rspN_valid && rspN_ready with no new acceptance for N -> rspN_valid <= 0. rspN_inst and rspN_err retain their values (don't-care).
- Back-to-back: rspN_ready=1 together with a new acceptance for N in the same cycle -> rspN_valid stays 1 with new data, giving 1 access/cycle throughput.
- A stalled requester never blocks the other: the ineligible side is excluded from arbitration.
- Request signals need not be held stable by the requester, since the arbiter accepts only when ready.

Test Plan:
- Reset, then req0 only, addr 0x0000_0008, ROM word[2]=0x3401_0020 -> req0_ready=1 and rom_ce=1 in cycle 0; rsp0_valid=1 with rsp0_inst=0x3401_0020, rsp0_err=0 in cycle 1.
- Both requesters valid continuously, rsp ready held 1 -> grants alternate 0,1,0,1; rom_addr alternates between req0_addr and req1_addr.
- Backpressure: rsp0_ready=0 after the first response, both requesters valid -> req0_ready stays 0, every grant goes to requester 1, rsp0_inst is held; raising rsp0_ready re-enables requester 0 in the same cycle.
- Misaligned: req1_addr=0x0000_0006 -> rom_ce=0 in that cycle; next cycle rsp1_valid=1, rsp1_err=1, rsp1_inst=0.
- Streaming: req0 valid for addresses 0x0,0x4,0x8,0xC with rsp0_ready=1 -> four consecutive acceptances and four consecutive responses, rsp0_valid never dropping.
- Reset mid-operation: rst=1 while rsp0_valid=1 and rsp1_valid=1 -> both valids are 0 the next cycle; after rst falls with both requesters valid, requester 0 is granted first.

Source files
------------

// File: rtl/inst_rom_arbiter_if.sv
// Requester/response handshakes and ROM read port shared by the instruction ROM arbiter.
// The slave modport is the arbiter's view; master is the requester/ROM side.
interface inst_rom_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic              req0_ready;
    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_inst;
    logic              rsp0_err;
    logic              rsp0_ready;

    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic              req1_ready;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_inst;
    logic              rsp1_err;
    logic              rsp1_ready;

    logic              rom_ce;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_inst;

    modport slave (
        input  req0_valid, req0_addr, rsp0_ready,
        input  req1_valid, req1_addr, rsp1_ready,
        input  rom_inst,
        output req0_ready, rsp0_valid, rsp0_inst, rsp0_err,
        output req1_ready, rsp1_valid, rsp1_inst, rsp1_err,
        output rom_ce, rom_addr
    );

    modport master (
        output req0_valid, req0_addr, rsp0_ready,
        output req1_valid, req1_addr, rsp1_ready,
        output rom_inst,
        input  req0_ready, rsp0_valid, rsp0_inst, rsp0_err,
        input  req1_ready, rsp1_valid, rsp1_inst, rsp1_err,
        input  rom_ce, rom_addr
    );
endinterface

// File: rtl/inst_rom_arbiter.sv
// Round-robin sharing of one combinational instruction ROM port between two requesters,
// with a registered, held-until-consumed response slot per requester.
module inst_rom_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    inst_rom_arbiter_if.slave  bus
);
    logic              rsp0_valid_q, rsp0_valid_d;
    logic [DATA_W-1:0] rsp0_inst_q,  rsp0_inst_d;
    logic              rsp0_err_q,   rsp0_err_d;
    logic              rsp1_valid_q, rsp1_valid_d;
    logic [DATA_W-1:0] rsp1_inst_q,  rsp1_inst_d;
    logic              rsp1_err_q,   rsp1_err_d;
    logic              last_grant_q, last_grant_d;

    logic              cand0, cand1;
    logic              grant0, grant1;
    logic              aligned;
    logic [ADDR_W-1:0] rom_addr_d;
    logic [DATA_W-1:0] acc_inst;

    always_comb begin
        // A response being consumed this cycle frees its slot for a new acceptance.
        cand0 = bus.req0_valid && (!rsp0_valid_q || bus.rsp0_ready);
        cand1 = bus.req1_valid && (!rsp1_valid_q || bus.rsp1_ready);

        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            if (cand0 && cand1) begin
                grant0 = last_grant_q;
                grant1 = !last_grant_q;
            end else begin
                grant0 = cand0;
                grant1 = cand1;
            end
        end

        rom_addr_d = '0;
        if (grant0)      rom_addr_d = bus.req0_addr;
        else if (grant1) rom_addr_d = bus.req1_addr;

        aligned  = (rom_addr_d[1:0] == 2'b00);
        acc_inst = aligned ? bus.rom_inst : '0;

        rsp0_valid_d = rsp0_valid_q && !bus.rsp0_ready;
        rsp0_inst_d  = rsp0_inst_q;
        rsp0_err_d   = rsp0_err_q;
        rsp1_valid_d = rsp1_valid_q && !bus.rsp1_ready;
        rsp1_inst_d  = rsp1_inst_q;
        rsp1_err_d   = rsp1_err_q;
        last_grant_d = last_grant_q;

        if (grant0) begin
            rsp0_valid_d = 1'b1;
            rsp0_inst_d  = acc_inst;
            rsp0_err_d   = !aligned;
            last_grant_d = 1'b0;
        end
        if (grant1) begin
            rsp1_valid_d = 1'b1;
            rsp1_inst_d  = acc_inst;
            rsp1_err_d   = !aligned;
            last_grant_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp0_valid_q <= 1'b0;
            rsp0_inst_q  <= '0;
            rsp0_err_q   <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp1_inst_q  <= '0;
            rsp1_err_q   <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            rsp0_valid_q <= rsp0_valid_d;
            rsp0_inst_q  <= rsp0_inst_d;
            rsp0_err_q   <= rsp0_err_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp1_inst_q  <= rsp1_inst_d;
            rsp1_err_q   <= rsp1_err_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.rom_addr   = rom_addr_d;
    assign bus.rom_ce     = (grant0 || grant1) && aligned;
    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp0_inst  = rsp0_inst_q;
    assign bus.rsp0_err   = rsp0_err_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp1_inst  = rsp1_inst_q;
    assign bus.rsp1_err   = rsp1_err_q;
endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Bench for inst_rom_arbiter: directed scenarios plus randomized traffic against a
// slot/round-robin reference model.
module tb_inst_rom_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    inst_rom_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    inst_rom_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] rom_mem [16];
    assign bus.rom_inst = bus.rom_ce ? rom_mem[bus.rom_addr[5:2]] : 32'hDEAD_BEEF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one response slot per requester, plus who won last.
    logic        m_valid [2];
    logic [31:0] m_inst  [2];
    logic        m_err   [2];
    int          m_last;

    logic        t_rst;
    logic        t_v [2];
    logic [31:0] t_a [2];
    logic        t_r [2];

    function automatic int exp_grant();
        bit c [2];
        if (t_rst) return -1;
        for (int n = 0; n < 2; n++) c[n] = t_v[n] && (!m_valid[n] || t_r[n]);
        if (c[0] && c[1]) return (m_last == 0) ? 1 : 0;
        if (c[0]) return 0;
        if (c[1]) return 1;
        return -1;
    endfunction

    function automatic logic [31:0] exp_rom_addr();
        int g = exp_grant();
        return (g < 0) ? 32'h0 : t_a[g];
    endfunction

    function automatic logic exp_rom_ce();
        int g = exp_grant();
        return (g >= 0) && (t_a[g][1:0] == 2'b00);
    endfunction

    task automatic apply(input logic r, input logic v0, input logic [31:0] a0, input logic rr0,
                         input logic v1, input logic [31:0] a1, input logic rr1);
        t_rst = r; t_v[0] = v0; t_a[0] = a0; t_r[0] = rr0;
        t_v[1] = v1; t_a[1] = a1; t_r[1] = rr1;
        rst = r;
        bus.req0_valid = v0; bus.req0_addr = a0; bus.rsp0_ready = rr0;
        bus.req1_valid = v1; bus.req1_addr = a1; bus.rsp1_ready = rr1;
        #1;
    endtask

    task automatic advance();
        int g = exp_grant();
        if (t_rst) begin
            for (int n = 0; n < 2; n++) begin
                m_valid[n] = 1'b0; m_inst[n] = 32'h0; m_err[n] = 1'b0;
            end
            m_last = 1;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (g == n) begin
                    m_valid[n] = 1'b1;
                    m_err[n]   = (t_a[n][1:0] != 2'b00);
                    m_inst[n]  = m_err[n] ? 32'h0 : rom_mem[t_a[n][5:2]];
                    m_last     = n;
                end else if (m_valid[n] && t_r[n]) begin
                    m_valid[n] = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply(1, 1, 32'h0, 1, 1, 32'h4, 1);
        checks++;
        if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_grant got=%b%b exp=00", bus.req0_ready, bus.req1_ready);
        end
        advance();
        apply(1, 0, 32'h0, 0, 0, 32'h0, 0);
        checks++;
        if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%b%b exp=00", bus.rsp0_valid, bus.rsp1_valid);
        end
        checks++;
        if (bus.rsp0_inst !== 32'h0 || bus.rsp1_inst !== 32'h0 ||
            bus.rsp0_err !== 1'b0 || bus.rsp1_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_data got=%h/%h err=%b%b exp=0", bus.rsp0_inst, bus.rsp1_inst,
                     bus.rsp0_err, bus.rsp1_err);
        end
        advance();
    endtask

    task automatic test_single_fetch();
        apply(0, 1, 32'h8, 1, 0, 32'h0, 1);
        checks++;
        if (bus.req0_ready !== 1'b1 || bus.rom_ce !== 1'b1 || bus.rom_addr !== 32'h8) begin
            failures++;
            $display("FAIL single_grant got ready=%b ce=%b addr=%h exp 1 1 00000008",
                     bus.req0_ready, bus.rom_ce, bus.rom_addr);
        end
        advance();
        apply(0, 0, 32'h0, 1, 0, 32'h0, 1);
        checks++;
        if (bus.rsp0_valid !== 1'b1 || bus.rsp0_inst !== 32'h3401_0020 || bus.rsp0_err !== 1'b0) begin
            failures++;
            $display("FAIL single_rsp got v=%b inst=%h err=%b exp 1 34010020 0",
                     bus.rsp0_valid, bus.rsp0_inst, bus.rsp0_err);
        end
        advance();
    endtask

    task automatic test_alternate();
        int prev = m_last;
        int ag;
        for (int i = 0; i < 8; i++) begin
            apply(0, 1, 32'h20 + 32'(4 * i), 1, 1, 32'h30 + 32'(4 * i), 1);
            ag = bus.req0_ready ? 0 : (bus.req1_ready ? 1 : -1);
            checks++;
            if (ag != 1 - prev || (bus.req0_ready && bus.req1_ready)) begin
                failures++;
                $display("FAIL alternate cycle %0d got=%0d exp=%0d", i, ag, 1 - prev);
            end
            checks++;
            if (bus.rom_addr !== (prev == 0 ? t_a[1] : t_a[0])) begin
                failures++;
                $display("FAIL alternate_addr got=%h exp=%h", bus.rom_addr,
                         (prev == 0 ? t_a[1] : t_a[0]));
            end
            prev = 1 - prev;
            advance();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held = rom_mem[4];
        apply(0, 1, 32'h10, 1, 0, 32'h0, 1);
        advance();
        for (int i = 0; i < 5; i++) begin
            apply(0, 1, 32'h14, 0, 1, 32'h20 + 32'(4 * i), 1);
            checks++;
            if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b1) begin
                failures++;
                $display("FAIL backpressure_grant got=%b%b exp=01", bus.req0_ready, bus.req1_ready);
            end
            checks++;
            if (bus.rsp0_valid !== 1'b1 || bus.rsp0_inst !== held) begin
                failures++;
                $display("FAIL backpressure_hold got v=%b inst=%h exp 1 %h",
                         bus.rsp0_valid, bus.rsp0_inst, held);
            end
            advance();
        end
        apply(0, 1, 32'h18, 1, 1, 32'h30, 1);
        checks++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_release got=%b%b exp=10", bus.req0_ready, bus.req1_ready);
        end
        advance();
    endtask

    task automatic test_misaligned();
        apply(0, 0, 32'h0, 1, 1, 32'h6, 1);
        checks++;
        if (bus.req1_ready !== 1'b1 || bus.rom_ce !== 1'b0 || bus.rom_addr !== 32'h6) begin
            failures++;
            $display("FAIL misaligned_drive got ready=%b ce=%b addr=%h exp 1 0 00000006",
                     bus.req1_ready, bus.rom_ce, bus.rom_addr);
        end
        advance();
        apply(0, 0, 32'h0, 1, 0, 32'h0, 1);
        checks++;
        if (bus.rsp1_valid !== 1'b1 || bus.rsp1_err !== 1'b1 || bus.rsp1_inst !== 32'h0) begin
            failures++;
            $display("FAIL misaligned_rsp got v=%b err=%b inst=%h exp 1 1 0",
                     bus.rsp1_valid, bus.rsp1_err, bus.rsp1_inst);
        end
        advance();
    endtask

    task automatic test_streaming();
        for (int i = 0; i < 5; i++) begin
            if (i < 4) apply(0, 1, 32'(4 * i), 1, 0, 32'h0, 1);
            else       apply(0, 0, 32'h0, 1, 0, 32'h0, 1);
            if (i < 4) begin
                checks++;
                if (bus.req0_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL stream_accept beat %0d got=%b exp=1", i, bus.req0_ready);
                end
            end
            if (i > 0) begin
                checks++;
                if (bus.rsp0_valid !== 1'b1 || bus.rsp0_inst !== rom_mem[i-1]) begin
                    failures++;
                    $display("FAIL stream_rsp beat %0d got v=%b inst=%h exp 1 %h",
                             i, bus.rsp0_valid, bus.rsp0_inst, rom_mem[i-1]);
                end
            end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        apply(0, 1, 32'h0, 1, 0, 32'h0, 1);
        advance();
        apply(0, 0, 32'h0, 0, 1, 32'h4, 1);
        advance();
        apply(1, 1, 32'h8, 0, 1, 32'hC, 0);
        checks++;
        if (bus.rsp0_valid !== 1'b1 || bus.rsp1_valid !== 1'b1) begin
            failures++;
            $display("FAIL mid_pre_valid got=%b%b exp=11", bus.rsp0_valid, bus.rsp1_valid);
        end
        advance();
        apply(0, 1, 32'h8, 1, 1, 32'hC, 1);
        checks++;
        if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_cleared got=%b%b exp=00", bus.rsp0_valid, bus.rsp1_valid);
        end
        checks++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_first_grant got=%b%b exp=10", bus.req0_ready, bus.req1_ready);
        end
        advance();
    endtask

    task automatic test_random();
        logic [31:0] a [2];
        for (int i = 0; i < 400; i++) begin
            for (int n = 0; n < 2; n++) begin
                a[n] = $urandom();
                if ($urandom_range(0, 3) != 0) a[n][1:0] = 2'b00;
            end
            apply(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 3) != 0), a[0],
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) != 0), a[1],
                  1'($urandom_range(0, 2) != 0));
            checks++;
            if (bus.req0_ready !== (exp_grant() == 0) || bus.req1_ready !== (exp_grant() == 1)) begin
                failures++;
                $display("FAIL rand_grant cyc %0d got=%b%b exp_grant=%0d", i,
                         bus.req0_ready, bus.req1_ready, exp_grant());
            end
            checks++;
            if (bus.rom_ce !== exp_rom_ce() || bus.rom_addr !== exp_rom_addr()) begin
                failures++;
                $display("FAIL rand_rom cyc %0d got ce=%b addr=%h exp ce=%b addr=%h", i,
                         bus.rom_ce, bus.rom_addr, exp_rom_ce(), exp_rom_addr());
            end
            checks++;
            if (bus.rsp0_valid !== m_valid[0] || bus.rsp1_valid !== m_valid[1]) begin
                failures++;
                $display("FAIL rand_valid cyc %0d got=%b%b exp=%b%b", i,
                         bus.rsp0_valid, bus.rsp1_valid, m_valid[0], m_valid[1]);
            end
            if (m_valid[0]) begin
                checks++;
                if (bus.rsp0_inst !== m_inst[0] || bus.rsp0_err !== m_err[0]) begin
                    failures++;
                    $display("FAIL rand_rsp0 cyc %0d got %h/%b exp %h/%b", i,
                             bus.rsp0_inst, bus.rsp0_err, m_inst[0], m_err[0]);
                end
            end
            if (m_valid[1]) begin
                checks++;
                if (bus.rsp1_inst !== m_inst[1] || bus.rsp1_err !== m_err[1]) begin
                    failures++;
                    $display("FAIL rand_rsp1 cyc %0d got %h/%b exp %h/%b", i,
                             bus.rsp1_inst, bus.rsp1_err, m_inst[1], m_err[1]);
                end
            end
            advance();
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 16; i++) rom_mem[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0103;
        rom_mem[2] = 32'h3401_0020;
        for (int n = 0; n < 2; n++) begin
            m_valid[n] = 1'b0; m_inst[n] = 32'h0; m_err[n] = 1'b0;
        end
        m_last = 1;
        test_reset();
        test_single_fetch();
        test_alternate();
        test_backpressure();
        test_misaligned();
        test_streaming();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
